transceiver_reset_ctrl: RTL
===========================

# transceiver_reset_ctrl

Reset sequencer for one channel of the serial-link transceiver PHY wrapper: drives the four PHY resets (TX/RX analog, TX/RX digital) in the required order, gated on calibration, serial-PLL lock, CDR lock and word-alignment status. It sits between the board reset/PLL logic and the PHY instance, and gives the link layer clean `tx_ready`/`rx_ready` qualifiers. It also restarts the RX path automatically when CDR lock or word sync is lost.

## Interface
Parameters (all durations in `clk` cycles, counters 20 bits wide):
- `T_ARST`, 8000, minimum analog-reset assertion time (TX and RX).
- `T_DRST`, 64, digital-reset hold after prerequisites are met.
- `T_LTD`, 500, cycles `rx_is_lockedtodata` must stay continuously high before RX digital reset is released.
- `T_LTD_TIMEOUT`, 100000, maximum wait for CDR lock before RX is re-reset.
- `T_SYNC_LOSS`, 1024, consecutive cycles of `rx_syncstatus` low in RX_READY that trigger an RX restart.

Ports:
- `clk`  in  1  free-running system clock; the only clock in the block.
- `reset`  in  1  synchronous, active-high.
- `pll_locked`  in  1  TX serial-clock PLL lock (async).
- `tx_cal_busy`  in  1  PHY TX calibration busy (async).
- `rx_cal_busy`  in  1  PHY RX calibration busy (async).
- `rx_is_lockedtodata`  in  1  CDR data lock (async).
- `rx_syncstatus`  in  1  word aligner sync (async).
- `tx_analogreset`, `tx_digitalreset`, `rx_analogreset`, `rx_digitalreset`  out  1 each  PHY resets, registered.
- `tx_ready`, `rx_ready`  out  1 each  path usable, registered.
- `rx_relock_count`  out  8  saturating count of automatic RX restarts.

## Operation
- All five async inputs pass through 2-flop synchronizers; FSMs act only on synchronized versions.
- TX FSM: TX_ARST (tx_analogreset=1, tx_digitalreset=1) → TX_WAIT (analog=0, digital=1) → TX_DRST (digital=1) → TX_READY (both 0, tx_ready=1).
  - TX_ARST → TX_WAIT after exactly `T_ARST` cycles in state.
  - TX_WAIT → TX_DRST when `pll_locked`=1 and `tx_cal_busy`=0 on the same cycle.
  - TX_DRST → TX_READY after `T_DRST` cycles; any prerequisite drop during TX_DRST returns to TX_WAIT, counter cleared.
  - TX_READY → TX_WAIT on `pll_locked`=0 (digital reset reasserts; no analog reset).
- RX FSM: RX_ARST (rx_analogreset=1, rx_digitalreset=1) → RX_WAIT_CAL → RX_WAIT_LTD → RX_DRST → RX_READY (both 0, rx_ready=1). rx_digitalreset=1 in every state except RX_READY.
  - RX_ARST → RX_WAIT_CAL after `T_ARST` cycles.
  - RX_WAIT_CAL → RX_WAIT_LTD when `rx_cal_busy`=0.
  - RX_WAIT_LTD: stability counter counts while lockedtodata=1, clears when 0; reaching `T_LTD` → RX_DRST. Timeout counter reaching `T_LTD_TIMEOUT` → RX_ARST (takes priority if both hit same cycle).
  - RX_DRST → RX_READY after `T_DRST` cycles; lockedtodata=0 → RX_WAIT_LTD.
  - RX_READY: lockedtodata=0 → RX_ARST; syncstatus low for `T_SYNC_LOSS` consecutive cycles → RX_ARST. Each such exit (and each LTD timeout) increments `rx_relock_count`, saturating at 255.
- TX and RX FSMs are independent; RX does not wait for TX.

## Timing
- Reset values: all four PHY resets = 1, `tx_ready`=`rx_ready`=0, `rx_relock_count`=0, FSMs in TX_ARST/RX_ARST with counters 0.
- `reset` asserted mid-sequence returns everything to reset values on the next edge, regardless of state.
- Outputs are registered from state: an output changes on the same edge as the state transition.
- With `reset` released at edge 0, analog resets fall at edge `T_ARST`.
- Input-to-action latency: 2 cycles of synchronizer plus 1 cycle of FSM register.
- Counters clear on every state entry; `T_*` values ≥ 1.

## Test plan
Bench overrides: `T_ARST`=16, `T_DRST`=4, `T_LTD`=8, `T_LTD_TIMEOUT`=64, `T_SYNC_LOSS`=4.
- Nominal bring-up: PLL locked, cal_busy low, lockedtodata and syncstatus high from start. Required: analog resets fall at cycle 16. `tx_ready` and `rx_ready` rise at cycle ≤ 16+3+4+1 and ≤ 16+3+8+4+1 respectively, in order analog → digital → ready.
- Cal hold-off: `tx_cal_busy` high until cycle 100. Required: `tx_digitalreset` stays 1 until cycle ≥ 100+3+4; `rx_ready` is unaffected.
- CDR flaky: lockedtodata toggles every 5 cycles. Required: no RX_DRST entry. At 64 cycles in RX_WAIT_LTD, `rx_analogreset` reasserts and `rx_relock_count`=1.
- Sync loss: in RX_READY, drop syncstatus for 3 cycles. Required: no reaction. Drop it for 4 cycles. Required: `rx_ready`→0, `rx_analogreset`→1, `rx_relock_count` incremented, TX outputs unchanged.
- PLL loss in TX_READY. Required: `tx_ready`=0 and `tx_digitalreset`=1 three cycles later, `tx_analogreset` stays 0. Relock PLL. Required: `tx_ready` returns after 4 cycles of TX_DRST.
- Mid-sequence reset pulsed during RX_WAIT_LTD with count at 255 forced by 255+ timeouts. Required: all outputs return to reset values next edge and the counter reads 0; saturation at 255 was verified beforehand.

Source files
------------

// File: rtl/transceiver_reset_ctrl_if.sv
// PHY-facing signal bundle of one transceiver channel: async status in, registered resets and
// ready qualifiers out.
interface transceiver_reset_ctrl_if;
   logic       pll_locked;
   logic       tx_cal_busy;
   logic       rx_cal_busy;
   logic       rx_is_lockedtodata;
   logic       rx_syncstatus;
   logic       tx_analogreset;
   logic       tx_digitalreset;
   logic       rx_analogreset;
   logic       rx_digitalreset;
   logic       tx_ready;
   logic       rx_ready;
   logic [7:0] rx_relock_count;

   modport master (
      input  pll_locked, tx_cal_busy, rx_cal_busy, rx_is_lockedtodata, rx_syncstatus,
      output tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset,
      output tx_ready, rx_ready, rx_relock_count
   );

   modport slave (
      output pll_locked, tx_cal_busy, rx_cal_busy, rx_is_lockedtodata, rx_syncstatus,
      input  tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset,
      input  tx_ready, rx_ready, rx_relock_count
   );
endinterface

// File: rtl/transceiver_reset_ctrl.sv
// Reset sequencer for one transceiver channel: independent TX and RX FSMs order the PHY analog
// and digital resets and restart RX automatically on CDR-lock or word-sync loss.
module transceiver_reset_ctrl #(
   parameter int unsigned T_ARST        = 8000,
   parameter int unsigned T_DRST        = 64,
   parameter int unsigned T_LTD         = 500,
   parameter int unsigned T_LTD_TIMEOUT = 100000,
   parameter int unsigned T_SYNC_LOSS   = 1024
) (
   input logic                      clk,
   input logic                      reset,
   transceiver_reset_ctrl_if.master phy
);
   typedef logic [19:0] cnt_t;

   // Counters hold "cycles already spent", so a duration T ends when the count equals T-1.
   localparam cnt_t ArstLast  = cnt_t'(T_ARST - 1);
   localparam cnt_t DrstLast  = cnt_t'(T_DRST - 1);
   localparam cnt_t LtdLast   = cnt_t'(T_LTD - 1);
   localparam cnt_t LtdToLast = cnt_t'(T_LTD_TIMEOUT - 1);
   localparam cnt_t LossLast  = cnt_t'(T_SYNC_LOSS - 1);

   typedef enum logic [1:0] {TxArst, TxWait, TxDrst, TxReady} tx_state_e;
   typedef enum logic [2:0] {RxArst, RxWaitCal, RxWaitLtd, RxDrst, RxReady} rx_state_e;

   logic [4:0] sync1_q, sync2_q;
   logic       pll_s, tx_cal_s, rx_cal_s, ltd_s, sync_s;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {phy.pll_locked, phy.tx_cal_busy, phy.rx_cal_busy, phy.rx_is_lockedtodata,
                     phy.rx_syncstatus};
         sync2_q <= sync1_q;
      end
   end

   assign {pll_s, tx_cal_s, rx_cal_s, ltd_s, sync_s} = sync2_q;

   tx_state_e tx_state_q, tx_state_d;
   cnt_t      tx_cnt_q, tx_cnt_d;
   logic      tx_ok;
   logic      tx_arst_q, tx_drst_q, tx_ready_q;

   assign tx_ok = pll_s & ~tx_cal_s;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + 1'b1;
      unique case (tx_state_q)
         TxArst:  if (tx_cnt_q == ArstLast) tx_state_d = TxWait;
         TxWait:  if (tx_ok) tx_state_d = TxDrst;
         TxDrst: begin
            if (!tx_ok)                     tx_state_d = TxWait;
            else if (tx_cnt_q == DrstLast)  tx_state_d = TxReady;
         end
         TxReady: if (!pll_s) tx_state_d = TxWait;
         default: tx_state_d = TxArst;
      endcase
      if (tx_state_d != tx_state_q) tx_cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state_q <= TxArst;
         tx_cnt_q   <= '0;
         tx_arst_q  <= 1'b1;
         tx_drst_q  <= 1'b1;
         tx_ready_q <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_arst_q  <= (tx_state_d == TxArst);
         tx_drst_q  <= (tx_state_d != TxReady);
         tx_ready_q <= (tx_state_d == TxReady);
      end
   end

   rx_state_e rx_state_q, rx_state_d;
   cnt_t      rx_cnt_q, rx_cnt_d;
   cnt_t      ltd_cnt_q, ltd_cnt_d;
   cnt_t      loss_cnt_q, loss_cnt_d;
   logic      relock;
   logic      rx_arst_q, rx_drst_q, rx_ready_q;
   logic [7:0] relock_cnt_q;

   // rx_cnt doubles as the ARST/DRST duration and the CDR-lock timeout in RxWaitLtd.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + 1'b1;
      ltd_cnt_d  = ltd_s ? ltd_cnt_q + 1'b1 : '0;
      loss_cnt_d = sync_s ? '0 : loss_cnt_q + 1'b1;
      relock     = 1'b0;
      unique case (rx_state_q)
         RxArst:    if (rx_cnt_q == ArstLast) rx_state_d = RxWaitCal;
         RxWaitCal: if (!rx_cal_s) rx_state_d = RxWaitLtd;
         RxWaitLtd: begin
            if (rx_cnt_q == LtdToLast) begin
               rx_state_d = RxArst;
               relock     = 1'b1;
            end else if (ltd_s && ltd_cnt_q == LtdLast) begin
               rx_state_d = RxDrst;
            end
         end
         RxDrst: begin
            if (!ltd_s)                     rx_state_d = RxWaitLtd;
            else if (rx_cnt_q == DrstLast)  rx_state_d = RxReady;
         end
         RxReady: begin
            if (!ltd_s || (!sync_s && loss_cnt_q == LossLast)) begin
               rx_state_d = RxArst;
               relock     = 1'b1;
            end
         end
         default: rx_state_d = RxArst;
      endcase
      if (rx_state_d != rx_state_q) begin
         rx_cnt_d   = '0;
         ltd_cnt_d  = '0;
         loss_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state_q   <= RxArst;
         rx_cnt_q     <= '0;
         ltd_cnt_q    <= '0;
         loss_cnt_q   <= '0;
         rx_arst_q    <= 1'b1;
         rx_drst_q    <= 1'b1;
         rx_ready_q   <= 1'b0;
         relock_cnt_q <= '0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         ltd_cnt_q  <= ltd_cnt_d;
         loss_cnt_q <= loss_cnt_d;
         rx_arst_q  <= (rx_state_d == RxArst);
         rx_drst_q  <= (rx_state_d != RxReady);
         rx_ready_q <= (rx_state_d == RxReady);
         if (relock && relock_cnt_q != 8'hFF) relock_cnt_q <= relock_cnt_q + 8'd1;
      end
   end

   assign phy.tx_analogreset  = tx_arst_q;
   assign phy.tx_digitalreset = tx_drst_q;
   assign phy.tx_ready        = tx_ready_q;
   assign phy.rx_analogreset  = rx_arst_q;
   assign phy.rx_digitalreset = rx_drst_q;
   assign phy.rx_ready        = rx_ready_q;
   assign phy.rx_relock_count = relock_cnt_q;
endmodule
